// File: rtl/led_pkg.sv
// Shared types and constants for the LED scan controller: scan states,
// the all-off segment pattern and the hex-to-segment table ({a,b,c,d,e,f,g}).
package led_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  // Entry n holds the pattern for hex digit n (entry 15 is listed first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

endpackage

// File: rtl/seg7_dec.sv
// Combinational hex nibble to seven-segment decoder, shared by all digits.
module seg7_dec
  import led_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for the selected nibble
  always_comb begin
    seg = SEG_TABLE[nib];
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// Four-digit multiplexed LED scan controller with shadow/active digit registers.
// Optional macro LED_SCAN_LZB_EN enables leading-zero blanking.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int unsigned SHOW_CYC  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       commit,
  input  logic       EN,
  output logic       commit_pend,
  output logic       frame_done,
  output logic [3:0] LED_sel,
  output logic [6:0] seg
);

  localparam int unsigned MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  scan_state_t      state_r;
  scan_state_t      state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [1:0]       dig_r;
  logic [1:0]       dig_nxt_s;
  logic             boundary_s;

  logic [3:0]       shadow_r [4];
  logic [3:0]       active_r [4];
  logic             commit_pend_r;
  logic             frame_done_r;
  logic [3:0]       led_sel_r;
  logic [6:0]       seg_r;

  logic [3:0]       nib_s;
  logic [6:0]       dec_s;
  logic             lzb_blank_s;
  logic [3:0]       sel_nxt_s;
  logic [6:0]       seg_nxt_s;

  // Scan state, dwell counter and digit index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_BLANK;
      cnt_r   <= CNT_ZERO;
      dig_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      dig_r   <= dig_nxt_s;
    end
  end

  // Next-state logic; the frame boundary is leaving SHOW of digit 3
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + CNT_ONE;
    dig_nxt_s   = dig_r;
    boundary_s  = 1'b0;
    case (state_r)
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_nxt_s = ST_SHOW;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_SHOW: begin
        if (cnt_r == SHOW_LAST) begin
          state_nxt_s = ST_BLANK;
          cnt_nxt_s   = CNT_ZERO;
          dig_nxt_s   = dig_r + 2'd1;
          boundary_s  = (dig_r == 2'd3);
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_BLANK;
        cnt_nxt_s   = CNT_ZERO;
        dig_nxt_s   = 2'd0;
      end
    endcase
  end

  // Outputs are registered from the next state, so decode the upcoming digit
  assign nib_s = active_r[dig_nxt_s];

  seg7_dec u_dec (
    .nib (nib_s),
    .seg (dec_s)
  );

`ifdef LED_SCAN_LZB_EN
  // Blank a non-rightmost digit when it and every digit above it are zero
  always_comb begin
    lzb_blank_s = (dig_nxt_s != 2'd0);
    for (int j = 1; j < 4; j++) begin
      if ((j >= int'(dig_nxt_s)) && (active_r[j] != 4'h0)) begin
        lzb_blank_s = 1'b0;
      end else begin
        lzb_blank_s = lzb_blank_s;
      end
    end
  end
`else
  assign lzb_blank_s = 1'b0;
`endif

  // Select and segment values for the cycle following this edge
  always_comb begin
    sel_nxt_s = 4'b1111;
    seg_nxt_s = SEG_BLANK;
    if (state_nxt_s == ST_SHOW) begin
      sel_nxt_s = ~(4'b0001 << dig_nxt_s);
      seg_nxt_s = lzb_blank_s ? SEG_BLANK : dec_s;
    end else begin
      sel_nxt_s = 4'b1111;
      seg_nxt_s = SEG_BLANK;
    end
  end

  // Digit storage, commit handshake and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        shadow_r[i] <= 4'h0;
        active_r[i] <= 4'h0;
      end
      commit_pend_r <= 1'b0;
      frame_done_r  <= 1'b0;
      led_sel_r     <= 4'b1111;
      seg_r         <= SEG_BLANK;
    end else begin
      if (wr_en) begin
        shadow_r[wr_addr] <= wr_data;
      end
      // Transfer reads the pre-write shadow; a commit on the boundary waits a frame
      if (boundary_s && commit_pend_r) begin
        for (int i = 0; i < 4; i++) begin
          active_r[i] <= shadow_r[i];
        end
      end
      commit_pend_r <= commit | (commit_pend_r & ~boundary_s);
      frame_done_r  <= boundary_s;
      led_sel_r     <= sel_nxt_s;
      seg_r         <= seg_nxt_s;
    end
  end

  assign commit_pend = commit_pend_r;
  assign frame_done  = frame_done_r;
  assign LED_sel     = led_sel_r;
  assign seg         = EN ? SEG_BLANK : seg_r;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl (SHOW_CYC=4, BLANK_CYC=1) with a frame-position model.
module tb_led_scan_ctrl;

  localparam int S     = 4;
  localparam int B     = 1;
  localparam int PER   = S + B;
  localparam int FRAME = 4 * PER;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       commit;
  logic       EN;
  logic       commit_pend;
  logic       frame_done;
  logic [3:0] LED_sel;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles since reset, digit registers, pending flag
  int         m_k = 0;
  bit         m_valid = 1'b0;
  logic       m_pend = 1'b0;
  logic [3:0] m_shadow [4];
  logic [3:0] m_active [4];

  logic [6:0] hex7 [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  led_scan_ctrl #(.SHOW_CYC(S), .BLANK_CYC(B)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .EN          (EN),
    .commit_pend (commit_pend),
    .frame_done  (frame_done),
    .LED_sel     (LED_sel),
    .seg         (seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_sel(input int k);
    int slot;
    slot = k % FRAME;
    if ((slot % PER) < B) return 4'b1111;
    return ~(4'b0001 << (slot / PER));
  endfunction

  function automatic logic [6:0] exp_seg(input int k);
    int slot;
    int d;
    slot = k % FRAME;
    d    = slot / PER;
    if (EN) return 7'b0;
    if ((slot % PER) < B) return 7'b0;
`ifdef LED_SCAN_LZB_EN
    if (d != 0) begin
      bit all_zero;
      all_zero = 1'b1;
      for (int j = d; j < 4; j++) if (m_active[j] != 4'h0) all_zero = 1'b0;
      if (all_zero) return 7'b0;
    end
`endif
    return hex7[m_active[d]];
  endfunction

  // Model advance on each active edge using the inputs the DUT sees
  always @(posedge clk) begin
    if (rst) begin
      m_k     <= 0;
      m_pend  <= 1'b0;
      m_valid <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] <= 4'h0;
        m_active[i] <= 4'h0;
      end
    end else begin
      m_k <= m_k + 1;
      if ((m_k % FRAME) == FRAME - 1) begin
        if (m_pend) m_active <= m_shadow;
        m_pend <= commit;
      end else begin
        m_pend <= m_pend | commit;
      end
      if (wr_en) m_shadow[wr_addr] <= wr_data;
    end
  end

  // Every-cycle comparison against the model on the inactive edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("LED_sel", LED_sel, exp_sel(m_k));
      chk("seg", seg, exp_seg(m_k));
      chk("frame_done", frame_done, (m_k > 0 && (m_k % FRAME) == 0) ? 1 : 0);
      chk("commit_pend", commit_pend, m_pend);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_slot(input int s);
    int n;
    n = 0;
    cyc();
    while ((m_k % FRAME) != s && n < 2 * FRAME) begin
      cyc();
      n++;
    end
    chk("wait_slot", m_k % FRAME, s);
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  logic [3:0] sel_seq [6] = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101};

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'h0; commit = 1'b0; EN = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_sel", LED_sel, 4'b1111);
    chk("rst_seg", seg, 7'b0);
    chk("rst_pend", commit_pend, 1'b0);
    chk("rst_fd", frame_done, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("startup_sel", LED_sel, sel_seq[i]);
    end
    while (m_k < FRAME) cyc();
    chk("fd_pulse", frame_done, 1'b1);
    cyc();
    chk("fd_low", frame_done, 1'b0);

    // Shadow writes without commit leave the display at zero
    wr(2'd0, 4'h1); wr(2'd1, 4'h2); wr(2'd2, 4'h3); wr(2'd3, 4'h4);
    wait_slot(1);
    chk("nocommit_d0", seg, 7'b1111110);
    commit = 1'b1; cyc(); commit = 1'b0;
    chk("pend_set", commit_pend, 1'b1);
    wait_slot(16);
`ifndef LED_SCAN_LZB_EN
    chk("precommit_d3", seg, 7'b1111110);
`endif
    wait_slot(0);
    chk("xfer_fd", frame_done, 1'b1);
    chk("xfer_pend", commit_pend, 1'b0);
    wait_slot(1);
    chk("xfer_d0", seg, 7'b0110000);
    wait_slot(16);
    chk("xfer_d3", seg, 7'b0110011);

    // Commit on the boundary is deferred one frame; write during transfer hits shadow only
    wait_slot(FRAME - 1);
    commit = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h9;
    cyc();
    commit = 1'b0; wr_en = 1'b0;
    chk("bnd_pend", commit_pend, 1'b1);
    wait_slot(1);
    chk("bnd_defer_d0", seg, 7'b0110000);
    wait_slot(FRAME - 1);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h7;
    cyc();
    wr_en = 1'b0;
    chk("bnd_xfer_pend", commit_pend, 1'b0);
    wait_slot(1);
    chk("prewrite_d0", seg, 7'b1111011);

    // Global blank is immediate and does not disturb the scan
    wait_slot(2);
    EN = 1'b1;
    #1;
    chk("en_seg", seg, 7'b0);
    chk("en_sel", LED_sel, 4'b1110);
    cyc();
    chk("en_sel2", LED_sel, 4'b1110);
    EN = 1'b0;
    #1;
    chk("en_restore", seg, 7'b1111011);

    // Reset mid-frame with a pending commit
    commit = 1'b1; cyc(); commit = 1'b0;
    wait_slot(11);
    chk("pre_rst_pend", commit_pend, 1'b1);
    chk("pre_rst_sel", LED_sel, 4'b1011);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_sel", LED_sel, 4'b1111);
    chk("mid_rst_seg", seg, 7'b0);
    chk("mid_rst_pend", commit_pend, 1'b0);
    chk("mid_rst_fd", frame_done, 1'b0);
    cyc();
    chk("restart_sel", LED_sel, 4'b1110);
    chk("restart_seg", seg, 7'b1111110);

`ifdef LED_SCAN_LZB_EN
    wr(2'd0, 4'h0); wr(2'd1, 4'h5); wr(2'd2, 4'h0); wr(2'd3, 4'h0);
    commit = 1'b1; cyc(); commit = 1'b0;
    wait_slot(0);
    wait_slot(1);
    chk("lzb_d0", seg, 7'b1111110);
    wait_slot(6);
    chk("lzb_d1", seg, 7'b1011011);
    wait_slot(11);
    chk("lzb_d2", seg, 7'b0);
    wait_slot(16);
    chk("lzb_d3", seg, 7'b0);
`endif

    // Randomized traffic checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 499) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 4'($urandom_range(0, 15));
      commit  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) EN = ~EN;
      cyc();
    end
    rst = 1'b0; wr_en = 1'b0; commit = 1'b0; EN = 1'b0;
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
